seg_disp_ctrl: RTL and testbench
================================

Name: seg_disp_ctrl

Overview:
Controller for the four-digit multiplexed seven-segment display. It generates the digit scan timing from a prescaler and shares the display between two requesters, A (result) and B (status), using a 4-phase req/ack handshake with fixed priority B > A. New values commit only at frame boundaries, so a frame is never torn. It also applies hex-to-segment decode, leading-zero blanking and blinking, and drives the board digit-select and segment pins directly.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (min 2)
BLINK_DIV, 64, full frames per blink half-period (min 1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req_a  input  1  requester A wants to display data_a
data_a  input  16  A value, 4 hex nibbles, [3:0] = digit 0 (rightmost)
ack_a  output  1  A handshake acknowledge
req_b  input  1  requester B (priority) wants to display data_b
data_b  input  16  B value
ack_b  output  1  B handshake acknowledge
blank_lz  input  1  enable leading-zero blanking
blink_en  input  1  enable display blinking
LEDSEL  output  4  digit select, active-low one-hot
LEDOUT  output  8  segments, active-low, bit7=dp, bits6:0=gfedcba

Behaviour:
- Prescaler cnt counts 0..SCAN_DIV-1 and wraps. tick = (cnt == SCAN_DIV-1). Digit index idx[1:0] increments on tick and wraps 3->0. frame_end = tick && idx==3.
- Blink: frame counter counts 0..BLINK_DIV-1 on frame_end. blink_phase toggles when it wraps.
- LEDSEL/LEDOUT are combinational decode of registered state only:
  - idx 0/1/2/3 -> LEDSEL 1110/1101/1011/0111
  - blink_en && blink_phase -> LEDSEL 1111, LEDOUT unchanged
- Decode of disp nibble (dp always off, bit7=1): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Leading-zero blanking (blank_lz=1): digit k (k=3..1) is blanked iff nibbles k..3 are all zero. Blanked digit -> LEDOUT FF. Digit 0 is never blanked.
- Arbiter FSM, states IDLE, PEND, ACK:
  - IDLE: if req_b, capture data_b into pend, src=B, go PEND. Else if req_a, capture data_a, src=A, go PEND.
  - PEND: on frame_end, disp <= pend, go ACK. A frame_end coinciding with the IDLE capture cycle does not commit; commit waits for the next frame_end.
  - ACK: ack_src registered high. Stays high while req_src high. When req_src is sampled low, ack drops next edge and the FSM returns to IDLE.
  - data_src is sampled only in the IDLE capture cycle and may change afterwards.
  - Requesters hold req until ack, then deassert. A req dropped before ack is ignored; the captured value still commits and ack is still given.
  - Losing requester keeps waiting and is served after the current handshake completes (re-arbitrated in IDLE).
- Latency: capture -> commit is ≤ 4*SCAN_DIV cycles. ack rises the edge after commit.
- Reset (rst=0, async):
  - cnt=0, idx=0, frame count=0, blink_phase=0
  - state=IDLE, pend=0, disp=16'h0000, ack_a=ack_b=0
  - Outputs immediately LEDSEL=1110, LEDOUT=C0
  - Reset mid-PEND/ACK aborts the transfer; the requester must re-request.
- Deassertion is synchronous to clk at the integration level; no synchronizer inside.

Test Plan:
(all with SCAN_DIV=4, BLINK_DIV=2; frame = 16 cycles)
1. Reset release, no req -> LEDSEL steps 1110,1101,1011,0111 every 4 clks. LEDOUT=C0 on all digits. Both acks 0.
2. req_a, data_a=16'h12AF -> ack_a rises 1 clk after next frame_end. Digits 0..3 show 8E,88,A4,F9. ack_a holds while req_a=1 and drops 1 clk after req_a=0.
3. req_a=req_b same cycle, A=16'h1234, B=16'h0005 -> B committed and acked first. A captured only after ack_b falls; A committed at a later frame_end; display then 1234.
4. blank_lz=1, disp=16'h0005 -> digits 3..1 LEDOUT=FF, digit0=92. disp=16'h0000 -> digit0 C0, others FF. disp=16'h0100 -> digit3 FF, digits 2..0 = F9,C0,C0.
5. blink_en=1 -> LEDSEL=1111 for frames 2-3 and normal scanning for frames 0-1, repeating. LEDOUT sequence unaffected.
6. rst=0 asserted while in PEND -> same cycle: ack 0, LEDSEL=1110, LEDOUT=C0. After release, previously pending value never appears.

Source files
------------

// File: rtl/seg_disp_ctrl.sv
// Four-digit multiplexed seven-segment display controller.
// Scans the digits from a prescaler, arbitrates two requesters (B over A)
// with a 4-phase req/ack handshake, and commits new values only at frame
// boundaries. Drives active-low digit-select and segment pins directly.
module seg_disp_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] data_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        ack_b,
  input  logic        blank_lz,
  input  logic        blink_en,
  output logic [3:0]  LEDSEL,
  output logic [7:0]  LEDOUT
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACK} state_t;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [FRM_W-1:0] frm;
  logic             blink_phase;
  logic             tick;
  logic             frame_end;

  state_t      state, state_nxt;
  logic        src_b, src_b_nxt;
  logic [15:0] pend, pend_nxt;
  logic [15:0] disp, disp_nxt;
  logic        ack_a_nxt, ack_b_nxt;
  logic        req_src, ack_src;
  logic [3:0]  nib;

  // Hex digit to active-low gfedcba pattern, decimal point kept off.
  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 8'hC0;
      4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;
      4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;
      4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;
      4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;
      4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;
      4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;
      4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;
      default: hex_seg = 8'h8E;
    endcase
  endfunction

  // A digit is a leading zero when it and every digit to its left are zero;
  // the rightmost digit always shows so a zero value still reads "0".
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] k);
    case (k)
      2'd3:    lz_blank = (v[15:12] == 4'h0);
      2'd2:    lz_blank = (v[15:8] == 8'h00);
      2'd1:    lz_blank = (v[15:4] == 12'h000);
      default: lz_blank = 1'b0;
    endcase
  endfunction

  assign tick      = (cnt == CNT_MAX);
  assign frame_end = tick && (idx == 2'd3);
  assign req_src   = src_b ? req_b : req_a;
  assign ack_src   = src_b ? ack_b : ack_a;

  // Prescaler and digit scan index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Frame counter; blink phase flips every BLINK_DIV frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frm         <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (frm == FRM_MAX) begin
        frm         <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frm <= frm + FRM_W'(1);
      end
    end
  end

  // Arbiter state, captured value, displayed value and registered acks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      src_b <= 1'b0;
      pend  <= 16'h0000;
      disp  <= 16'h0000;
      ack_a <= 1'b0;
      ack_b <= 1'b0;
    end else begin
      state <= state_nxt;
      src_b <= src_b_nxt;
      pend  <= pend_nxt;
      disp  <= disp_nxt;
      ack_a <= ack_a_nxt;
      ack_b <= ack_b_nxt;
    end
  end

  // Arbiter next state: a handshake only closes once ack has been seen high
  // and the owning requester has released its request.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_b || req_a) state_nxt = S_PEND;
      S_PEND:  if (frame_end) state_nxt = S_ACK;
      S_ACK:   if (ack_src && !req_src) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Arbiter datapath and ack values; ack is forced high for at least one
  // cycle so a request that was dropped early still sees its acknowledge.
  always_comb begin
    src_b_nxt = src_b;
    pend_nxt  = pend;
    disp_nxt  = disp;
    ack_a_nxt = 1'b0;
    ack_b_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_b) begin
          src_b_nxt = 1'b1;
          pend_nxt  = data_b;
        end else if (req_a) begin
          src_b_nxt = 1'b0;
          pend_nxt  = data_a;
        end
      end
      S_PEND: begin
        if (frame_end) disp_nxt = pend;
      end
      S_ACK: begin
        ack_a_nxt = !src_b && (!ack_src || req_src);
        ack_b_nxt = src_b && (!ack_src || req_src);
      end
      default: ;
    endcase
  end

  assign nib = disp[{idx, 2'b00} +: 4];

  // Pin decode from registered state only: digit select, blanking, blink.
  always_comb begin
    LEDSEL = (blink_en && blink_phase) ? 4'b1111 : ~(4'b0001 << idx);
    LEDOUT = (blank_lz && lz_blank(disp, idx)) ? 8'hFF : hex_seg(nib);
  end

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Scoreboard bench for seg_disp_ctrl with a short scan period and blink.
module tb_seg_disp_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;

  typedef struct packed {
    logic        src_b;
    logic [31:0] segs;   // [7:0] = digit 0 pattern ... [31:24] = digit 3
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [15:0] data_a = 16'h0, data_b = 16'h0;
  logic        ack_a, ack_b;
  logic        blank_lz = 1'b0, blink_en = 1'b0;
  logic [3:0]  LEDSEL;
  logic [7:0]  LEDOUT;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        q[$];
  logic [31:0] cur_exp = 32'hC0C0C0C0;
  logic        pa = 1'b0, pb = 1'b0, pra = 1'b0, prb = 1'b0;

  seg_disp_ctrl #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .blank_lz(blank_lz), .blink_en(blink_en),
    .LEDSEL(LEDSEL), .LEDOUT(LEDOUT)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic b, input logic [31:0] s);
    exp_t e;
    e.src_b = b;
    e.segs  = s;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Clock cycles since reset release; DUT scan position follows from it.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Monitor: pops the scoreboard on each ack rise, checks ack release
  // against the requests, and checks every digit slot against the display.
  always @(negedge clk) begin : monitor
    exp_t       e;
    int         di;
    logic [3:0] es;
    if (!rst) begin
      cur_exp = 32'hC0C0C0C0;
      pa = 1'b0; pb = 1'b0; pra = 1'b0; prb = 1'b0;
    end else begin
      if ((ack_a && !pa) || (ack_b && !pb)) begin
        chk("ack_rise_phase", cyc % 16, 1);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack_a=%0b ack_b=%0b, expected no ack", ack_a, ack_b);
        end else begin
          e = q.pop_front();
          chk("ack_src_b", ack_b, e.src_b);
          chk("ack_src_a", ack_a, !e.src_b);
          cur_exp = e.segs;
        end
      end
      if (pa) chk("ack_a_hold", ack_a, pra);
      if (pb) chk("ack_b_hold", ack_b, prb);
      if (cyc % 4 == 2) begin
        di = (cyc / 4) % 4;
        es = (blink_en && ((cyc / 32) % 2 == 1)) ? 4'b1111 : ~(4'b0001 << di);
        chk("ledsel", LEDSEL, es);
        chk("ledout", LEDOUT, cur_exp[8*di +: 8]);
      end
      pa = ack_a; pb = ack_b; pra = req_a; prb = req_b;
    end
  end

  // One requester handshake: raise req, wait for ack, hold, release.
  task automatic do_req(input logic b, input logic [15:0] d, input logic scramble, input logic pulse);
    int  n;
    logic got;
    if (b) begin data_b = d; req_b = 1'b1; end
    else   begin data_a = d; req_a = 1'b1; end
    got = 1'b0;
    for (n = 1; n <= 200 && !got; n++) begin
      @(posedge clk); #1;
      if (pulse && n == 1) begin
        if (b) req_b = 1'b0; else req_a = 1'b0;
      end
      if (scramble && n == 2) begin
        if (b) data_b = ~d; else data_a = ~d;
      end
      got = b ? ack_b : ack_a;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack for %0h, expected ack within 200 cycles", d);
      if (b) req_b = 1'b0; else req_a = 1'b0;
      return;
    end
    repeat (2) @(posedge clk);
    #1;
    if (b) req_b = 1'b0; else req_a = 1'b0;
    for (n = 0; n < 10 && (b ? ack_b : ack_a); n++) begin
      @(posedge clk); #1;
    end
    if (b ? ack_b : ack_a) begin
      checks++;
      errors++;
      $display("FAIL ack_release_timeout: got ack still high, expected low");
    end
  endtask

  initial begin : stimulus
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ledsel", LEDSEL, 4'b1110);
    chk("rst_ledout", LEDOUT, 8'hC0);
    chk("rst_ack_a", ack_a, 1'b0);
    chk("rst_ack_b", ack_b, 1'b0);
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    // Single A request; data changes after capture must not matter
    q.push_back(mk(1'b0, 32'hF9A4888E));
    do_req(1'b0, 16'h12AF, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;

    // Simultaneous requests: B first, then A
    q.push_back(mk(1'b1, 32'hC0C0C092));
    q.push_back(mk(1'b0, 32'hF9A4B099));
    fork
      do_req(1'b1, 16'h0005, 1'b0, 1'b0);
      do_req(1'b0, 16'h1234, 1'b0, 1'b0);
    join
    repeat (20) @(posedge clk);
    #1;

    // Leading-zero blanking (1234 has none, so enabling it now is invisible)
    blank_lz = 1'b1;
    q.push_back(mk(1'b0, 32'hFFFFFF92));
    do_req(1'b0, 16'h0005, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    q.push_back(mk(1'b1, 32'hFFFFFFC0));
    do_req(1'b1, 16'h0000, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    q.push_back(mk(1'b0, 32'hFFF9C0C0));
    do_req(1'b0, 16'h0100, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    q.push_back(mk(1'b0, 32'hFF83C0A1));
    do_req(1'b0, 16'h0B0D, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    q.push_back(mk(1'b1, 32'h9080F882));
    do_req(1'b1, 16'h9876, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    blank_lz = 1'b0;

    // Blinking
    blink_en = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    blink_en = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Reset while a transfer is pending
    for (n = 0; n < 40 && (cyc % 16 != 2); n++) begin
      @(posedge clk); #1;
    end
    chk("align_pend", cyc % 16, 2);
    data_a = 16'h7777;
    req_a  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_ledsel", LEDSEL, 4'b1110);
    chk("abort_ledout", LEDOUT, 8'hC0);
    chk("abort_ack_a", ack_a, 1'b0);
    chk("abort_ack_b", ack_b, 1'b0);
    req_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (48) @(posedge clk);
    #1;

    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
